ysyx_22040386_lsu: RTL and testbench

Load/store unit sitting directly downstream of the execute-stage ALU. It takes the ALU sum as the effective address plus the store operand, and runs one memory transaction per request on a simple valid/ready data-memory port. It returns sign- or zero-extended load data, or a store acknowledgement, to writeback over a second valid/ready handshake. It is a blocking, single-outstanding unit built around a 4-state FSM.

---
 rtl/ysyx_22040386_lsu.sv | 137 +++++++++++++
 tb/tb_ysyx_22040386_lsu.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040386_lsu.sv
// Blocking single-outstanding load/store unit: IDLE -> REQ -> WAIT -> RESP over valid/ready ports.
// Optional misalignment trap: define YSYX_22040386_LSU_MISALIGN_CHECK_EN.
module ysyx_22040386_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [2:0]  mem_op,
  input  logic        is_store,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rdata,
  output logic        err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic [2:0]  op_q;
  logic        store_q;

  logic [2:0]  off;
  logic [7:0]  size_mask;
  logic [15:0] wmask_wide;
  logic [63:0] shifted;
  logic [63:0] load_val;
  logic        in_req;

  assign off = addr_q[2:0];

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    size_mask = 8'hFF;
    case (op_q[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Lanes pushed past byte 7 fall off the top of the word.
  assign wmask_wide = {8'h00, size_mask} << off;
  assign shifted    = mem_rdata >> {off, 3'b000};

  always_comb begin
    load_val = shifted;
    case (op_q)
      3'b000:  load_val = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_val = {56'h0, shifted[7:0]};
      3'b101:  load_val = {48'h0, shifted[15:0]};
      3'b110:  load_val = {32'h0, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

`ifdef YSYX_22040386_LSU_MISALIGN_CHECK_EN
  logic err_q;
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (mem_op[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      default: misaligned = |addr[2:0];
    endcase
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_q  <= 64'h0;
      wdata_q <= 64'h0;
      rdata_q <= 64'h0;
      op_q    <= 3'b000;
      store_q <= 1'b0;
`ifdef YSYX_22040386_LSU_MISALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          addr_q  <= addr;
          wdata_q <= wdata;
          op_q    <= mem_op;
          store_q <= is_store;
          rdata_q <= 64'h0;
          state   <= S_REQ;
`ifdef YSYX_22040386_LSU_MISALIGN_CHECK_EN
          err_q   <= misaligned;
          if (misaligned) state <= S_RESP;
`endif
        end
        S_REQ:  if (mem_req_ready) state <= S_WAIT;
        S_WAIT: if (mem_rsp_valid) begin
          rdata_q <= store_q ? 64'h0 : load_val;
          state   <= S_RESP;
        end
        default: if (rsp_ready) state <= S_IDLE;
      endcase
    end
  end

  assign in_req        = (state == S_REQ);
  assign req_ready     = (state == S_IDLE);
  assign rsp_valid     = (state == S_RESP);
  assign rdata         = rdata_q;
  assign mem_req_valid = in_req;
  assign mem_addr      = {addr_q[63:3], 3'b000};
  assign mem_we        = in_req & store_q;
  assign mem_wdata     = in_req ? (wdata_q << {off, 3'b000}) : 64'h0;
  assign mem_wmask     = in_req ? wmask_wide[7:0] : 8'h00;

endmodule

// File: tb/tb_ysyx_22040386_lsu.sv
// Directed bench for ysyx_22040386_lsu: vector table at minimum latency plus backpressure,
// misalignment and mid-transaction reset sequences. Honours YSYX_22040386_LSU_MISALIGN_CHECK_EN.
module tb_ysyx_22040386_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [2:0]  mem_op = '0;
  logic        is_store = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rdata;
  logic        err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_22040386_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .wdata(wdata), .mem_op(mem_op), .is_store(is_store),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rdata(rdata), .err(err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] mrd;
    logic [63:0] exp_rd;
    logic [63:0] exp_ma;
    logic [7:0]  exp_mask;
    logic [63:0] exp_wd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic st, input logic [2:0] op,
                              input logic [63:0] a, input logic [63:0] wd, input logic [63:0] mrd,
                              input logic [63:0] exp_rd, input logic [63:0] exp_ma,
                              input logic [7:0] exp_mask, input logic [63:0] exp_wd);
    vec_t v;
    v.name = name; v.st = st; v.op = op; v.a = a; v.wd = wd; v.mrd = mrd;
    v.exp_rd = exp_rd; v.exp_ma = exp_ma; v.exp_mask = exp_mask; v.exp_wd = exp_wd;
    return v;
  endfunction

  task automatic issue(input logic st, input logic [2:0] op, input logic [63:0] a, input logic [63:0] wd);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; is_store = st; mem_op = op; addr = a; wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; addr = '0; wdata = '0; mem_op = '0; is_store = 1'b0;
  endtask

  // Minimum-latency transaction: REQ in cycle 1, response in cycle 2, rsp_valid in cycle 3.
  task automatic run_txn(input vec_t v);
    issue(v.st, v.op, v.a, v.wd);
    check({v.name, ".mem_req_valid"}, mem_req_valid, 1);
    check({v.name, ".req_ready_busy"}, req_ready, 0);
    check({v.name, ".mem_addr"}, mem_addr, v.exp_ma);
    check({v.name, ".mem_we"}, mem_we, v.st);
    if (v.st) begin
      check({v.name, ".mem_wmask"}, mem_wmask, v.exp_mask);
      check({v.name, ".mem_wdata"}, mem_wdata, v.exp_wd);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check({v.name, ".req_dropped"}, mem_req_valid, 0);
    mem_rsp_valid = 1'b1; mem_rdata = v.mrd;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    check({v.name, ".rsp_valid"}, rsp_valid, 1);
    check({v.name, ".rdata"}, rdata, v.exp_rd);
    check({v.name, ".err"}, err, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({v.name, ".rsp_done"}, rsp_valid, 0);
    check({v.name, ".req_ready_back"}, req_ready, 1);
  endtask

  initial begin
    vecs.push_back(mk("LB",  0, 3'b000, 64'h8000_0003, 0, 64'h1122_3344_8566_7788,
                      64'hFFFF_FFFF_FFFF_FF85, 64'h8000_0000, 8'h00, 64'h0));
    vecs.push_back(mk("LWU", 0, 3'b110, 64'h8000_0004, 0, 64'hF0E0_D0C0_0000_0001,
                      64'h0000_0000_F0E0_D0C0, 64'h8000_0000, 8'h00, 64'h0));
    vecs.push_back(mk("SH",  1, 3'b001, 64'h8000_0006, 64'hABCD, 64'hDEAD_BEEF_DEAD_BEEF,
                      64'h0, 64'h8000_0000, 8'hC0, 64'hABCD_0000_0000_0000));
    vecs.push_back(mk("LH",  0, 3'b001, 64'h8000_0002, 0, 64'h1122_3344_8566_7788,
                      64'hFFFF_FFFF_FFFF_8566, 64'h8000_0000, 8'h00, 64'h0));
    vecs.push_back(mk("LHU", 0, 3'b101, 64'h8000_0002, 0, 64'h1122_3344_8566_7788,
                      64'h0000_0000_0000_8566, 64'h8000_0000, 8'h00, 64'h0));
    vecs.push_back(mk("LW",  0, 3'b010, 64'h0000_0010, 0, 64'h0000_0000_8000_0001,
                      64'hFFFF_FFFF_8000_0001, 64'h0000_0010, 8'h00, 64'h0));
    vecs.push_back(mk("LD",  0, 3'b011, 64'h0000_0018, 0, 64'h0123_4567_89AB_CDEF,
                      64'h0123_4567_89AB_CDEF, 64'h0000_0018, 8'h00, 64'h0));
    vecs.push_back(mk("LBU", 0, 3'b100, 64'h0000_0007, 0, 64'hF000_0000_0000_0000,
                      64'h0000_0000_0000_00F0, 64'h0000_0000, 8'h00, 64'h0));
    vecs.push_back(mk("SB",  1, 3'b000, 64'h0000_0005, 64'h1234_5678_9ABC_DEFF, 64'h0,
                      64'h0, 64'h0000_0000, 8'h20, 64'hBCDE_FF00_0000_0000));
    vecs.push_back(mk("SD",  1, 3'b011, 64'h0000_0020, 64'hCAFE_BABE_DEAD_BEEF, 64'h0,
                      64'h0, 64'h0000_0020, 8'hFF, 64'hCAFE_BABE_DEAD_BEEF));
    vecs.push_back(mk("SW",  1, 3'b010, 64'h0000_0024, 64'h1122_3344, 64'h0,
                      64'h0, 64'h0000_0020, 8'hF0, 64'h1122_3344_0000_0000));
    vecs.push_back(mk("OP7", 0, 3'b111, 64'h0000_0008, 0, 64'h8000_0000_0000_0000,
                      64'h8000_0000_0000_0000, 64'h0000_0008, 8'h00, 64'h0));

    // Reset values
    #12;
    check("rst.req_ready", req_ready, 1);
    check("rst.mem_req_valid", mem_req_valid, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rdata", rdata, 0);
    check("rst.err", err, 0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.mem_we", mem_we, 0);
    check("rst.mem_wmask", mem_wmask, 0);
    check("rst.mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Backpressure on both handshakes; stray mem_rsp_valid in REQ/RESP must be ignored.
    issue(0, 3'b011, 64'h0000_0040, 0);
    for (int i = 0; i < 5; i++) begin
      mem_rsp_valid = (i == 2); mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      check("bp.mem_req_valid", mem_req_valid, 1);
      check("bp.mem_addr", mem_addr, 64'h40);
      check("bp.req_ready", req_ready, 0);
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("bp.wait_no_rsp", rsp_valid, 0);
    mem_rsp_valid = 1'b1; mem_rdata = 64'h5555_AAAA_1234_5678;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = (i == 1); mem_rdata = 64'hBAD1_BAD1_BAD1_BAD1;
      @(negedge clk);
      check("bp.rsp_valid", rsp_valid, 1);
      check("bp.rdata", rdata, 64'h5555_AAAA_1234_5678);
      check("bp.req_ready", req_ready, 0);
    end
    mem_rsp_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp.req_ready_back", req_ready, 1);

    // Misaligned doubleword load at offset 4
`ifdef YSYX_22040386_LSU_MISALIGN_CHECK_EN
    issue(0, 3'b011, 64'h8000_0004, 0);
    check("mis.no_bus", mem_req_valid, 0);
    check("mis.rsp_valid", rsp_valid, 1);
    check("mis.err", err, 1);
    check("mis.rdata", rdata, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("mis.req_ready", req_ready, 1);
    issue(1, 3'b010, 64'h0000_0006, 64'hAABB_CCDD);
    check("mis_sw.no_bus", mem_req_valid, 0);
    check("mis_sw.no_we", mem_we, 0);
    check("mis_sw.err", err, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
`else
    run_txn(mk("MIS_LD", 0, 3'b011, 64'h8000_0004, 0, 64'h89AB_CDEF_0123_4567,
               64'h0000_0000_89AB_CDEF, 64'h8000_0000, 8'h00, 64'h0));
    run_txn(mk("MIS_SW", 1, 3'b010, 64'h0000_0006, 64'hAABB_CCDD, 64'h0,
               64'h0, 64'h0000_0000, 8'hC0, 64'hCCDD_0000_0000_0000));
`endif

    // Asynchronous reset while waiting for the bus response
    issue(0, 3'b011, 64'h0000_0080, 0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rstw.req_ready", req_ready, 1);
    check("rstw.mem_req_valid", mem_req_valid, 0);
    check("rstw.rsp_valid", rsp_valid, 0);
    check("rstw.rdata", rdata, 0);
    check("rstw.err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("rstw.late_rsp", rsp_valid, 0);
    check("rstw.idle", req_ready, 1);
    run_txn(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
